// File: rtl/access_control_multi.sv
// Multi-user PIN access controller: per-slot enrolled PINs, verify/enroll/change/clear
// requests, per-user failed-attempt lockout and PIN-entry timeout.
module access_control_multi #(
    parameter int unsigned PIN_W          = 16,
    parameter int unsigned NUM_USERS      = 4,
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCK_CYCLES    = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned UID_W         = $clog2(NUM_USERS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             _Req_Valid,
    input  logic [1:0]       _Request,
    input  logic [UID_W-1:0] _User_Id,
    input  logic [PIN_W-1:0] _Data_In,
    input  logic             _Data_In_Load,
    output logic [2:0]       _Status_Frame,
    output logic             _Grant,
    output logic             _Busy
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_PIN = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_WAIT_NEW = 3'd3;
    localparam logic [2:0] S_RESULT   = 3'd4;

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_WAIT    = 3'b001;
    localparam logic [2:0] ST_GRANTED = 3'b010;
    localparam logic [2:0] ST_DENIED  = 3'b011;
    localparam logic [2:0] ST_LOCKED  = 3'b100;
    localparam logic [2:0] ST_DONE    = 3'b101;
    localparam logic [2:0] ST_TIMEOUT = 3'b110;
    localparam logic [2:0] ST_ERROR   = 3'b111;

    localparam logic [1:0] RQ_VERIFY = 2'b00;
    localparam logic [1:0] RQ_ENROLL = 2'b01;
    localparam logic [1:0] RQ_CHANGE = 2'b10;
    localparam logic [1:0] RQ_CLEAR  = 2'b11;

    logic [2:0]        state;
    logic [2:0]        status;
    logic              grant;
    logic [1:0]        req_q;
    logic [UID_W-1:0]  uid_q;
    logic [PIN_W-1:0]  pin_q;
    logic              load_prev;
    logic              rise_q;
    logic              load_rise;
    logic              waiting;
    logic [TO_W-1:0]   tcnt;
    logic              accept;
    logic              target_locked;
    logic              target_bad;
    logic              pin_match;
    logic              fail_limit;

    logic [PIN_W-1:0]  pins  [NUM_USERS];
    logic [NUM_USERS-1:0] valid;
    logic [FAIL_W-1:0] fails [NUM_USERS];
    logic [LOCK_W-1:0] locks [NUM_USERS];

    assign waiting       = (state == S_WAIT_PIN) || (state == S_WAIT_NEW);
    // Edges are only recognised while a PIN is awaited, so a load that rose in IDLE/RESULT
    // (including together with the request strobe) never leaks into the next transaction.
    assign load_rise     = _Data_In_Load && !load_prev && waiting;
    assign accept        = _Req_Valid && ((state == S_IDLE) || (state == S_RESULT));
    assign target_locked = (locks[_User_Id] != '0);
    assign target_bad    = (_Request == RQ_ENROLL) ? valid[_User_Id] : !valid[_User_Id];
    assign pin_match     = (pins[uid_q] == pin_q);
    assign fail_limit    = (fails[uid_q] >= FAIL_W'(MAX_TRIES - 1));

    assign _Status_Frame = status;
    assign _Grant        = grant;
    assign _Busy         = (state == S_WAIT_PIN) || (state == S_CHECK) || (state == S_WAIT_NEW);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_prev <= 1'b0;
            rise_q    <= 1'b0;
            pin_q     <= '0;
        end else begin
            load_prev <= _Data_In_Load;
            rise_q    <= load_rise;
            if (load_rise) begin
                pin_q <= _Data_In;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            status <= ST_IDLE;
            grant  <= 1'b0;
            req_q  <= '0;
            uid_q  <= '0;
            tcnt   <= '0;
            valid  <= '0;
            for (int unsigned i = 0; i < NUM_USERS; i++) begin
                pins[i]  <= '0;
                fails[i] <= '0;
                locks[i] <= '0;
            end
        end else begin
            grant <= 1'b0;
            for (int unsigned i = 0; i < NUM_USERS; i++) begin
                if (locks[i] != '0) begin
                    locks[i] <= locks[i] - 1'b1;
                end
            end

            case (state)
                S_IDLE, S_RESULT: begin
                    if (accept) begin
                        req_q <= _Request;
                        uid_q <= _User_Id;
                        if (target_locked) begin
                            state  <= S_RESULT;
                            status <= ST_LOCKED;
                        end else if (target_bad) begin
                            state  <= S_RESULT;
                            status <= ST_ERROR;
                        end else begin
                            state  <= S_WAIT_PIN;
                            status <= ST_WAIT;
                            tcnt   <= '0;
                        end
                    end
                end

                S_WAIT_PIN: begin
                    if (rise_q) begin
                        state <= S_CHECK;
                    end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state  <= S_RESULT;
                        status <= ST_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                S_CHECK: begin
                    state <= S_RESULT;
                    if (req_q == RQ_ENROLL) begin
                        pins[uid_q]  <= pin_q;
                        valid[uid_q] <= 1'b1;
                        status       <= ST_DONE;
                    end else if (pin_match) begin
                        case (req_q)
                            RQ_VERIFY: begin
                                fails[uid_q] <= '0;
                                status       <= ST_GRANTED;
                                grant        <= 1'b1;
                            end
                            RQ_CHANGE: begin
                                state <= S_WAIT_NEW;
                                tcnt  <= '0;
                            end
                            RQ_CLEAR: begin
                                valid[uid_q] <= 1'b0;
                                fails[uid_q] <= '0;
                                status       <= ST_DONE;
                            end
                            default: begin
                                status <= ST_ERROR;
                            end
                        endcase
                    end else if (fail_limit) begin
                        // Lock load overrides the per-cycle decrement issued above.
                        fails[uid_q] <= '0;
                        locks[uid_q] <= LOCK_W'(LOCK_CYCLES);
                        status       <= ST_LOCKED;
                    end else begin
                        fails[uid_q] <= fails[uid_q] + 1'b1;
                        status       <= ST_DENIED;
                    end
                end

                S_WAIT_NEW: begin
                    if (rise_q) begin
                        pins[uid_q] <= pin_q;
                        state       <= S_RESULT;
                        status      <= ST_DONE;
                    end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        state  <= S_RESULT;
                        status <= ST_TIMEOUT;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: begin
                    state  <= S_IDLE;
                    status <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_access_control_multi.sv
// Bench for access_control_multi: transaction-level user database model predicts the
// status/grant/busy outputs each cycle; directed scenarios pin key results to literals.
module tb_access_control_multi;

    localparam int T    = 30;
    localparam int LC   = 50;
    localparam int MAXT = 3;

    localparam logic [1:0] VERIFY = 2'b00;
    localparam logic [1:0] ENROLL = 2'b01;
    localparam logic [1:0] CHANGE = 2'b10;
    localparam logic [1:0] CLEAR  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  request = 2'b00;
    logic [1:0]  user_id = 2'b00;
    logic [15:0] data_in = 16'h0;
    logic        data_load = 1'b0;
    logic [2:0]  status_frame;
    logic        grant;
    logic        busy;

    access_control_multi #(
        .PIN_W(16), .NUM_USERS(4), .MAX_TRIES(MAXT), .LOCK_CYCLES(LC), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rst(rst), ._Req_Valid(req_valid), ._Request(request), ._User_Id(user_id),
        ._Data_In(data_in), ._Data_In_Load(data_load), ._Status_Frame(status_frame),
        ._Grant(grant), ._Busy(busy)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // user database model
    logic [15:0] m_pin [4];
    bit          m_valid [4];
    int          m_fail [4];
    longint      m_lock_free [4];

    logic [2:0] exp_status = 3'b000;
    logic       exp_grant  = 1'b0;
    logic       exp_busy   = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        n_cmp++;
        if (status_frame !== exp_status || grant !== exp_grant || busy !== exp_busy) begin
            n_bad++;
            $display("FAIL cycle %0d outputs: status/grant/busy got %b/%b/%b want %b/%b/%b",
                     cyc, status_frame, grant, busy, exp_status, exp_grant, exp_busy);
        end
    end

    task automatic check_lit(input string name, input logic [2:0] got, input logic [2:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pin[i] = 16'h0; m_valid[i] = 0; m_fail[i] = 0; m_lock_free[i] = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        exp_grant = 1'b0;
    endtask

    task automatic spur(input bit en);
        if (en && ($urandom % 3 == 0)) begin
            req_valid = 1'b1;
            request   = 2'($urandom);
            user_id   = 2'($urandom);
        end else begin
            req_valid = 1'b0;
        end
    endtask

    // Called right after the edge that entered a PIN wait; returns right after the load edge.
    task automatic load_pin(input int k_total, input logic [15:0] value, input bit sp);
        int k = 0;
        if (data_load) begin
            data_load = 1'b0;
            spur(sp);
            tick();
            k++;
        end
        while (k < k_total) begin
            spur(sp);
            tick();
            k++;
        end
        req_valid = 1'b0;
        data_in   = value;
        data_load = 1'b1;
        tick();
        data_in   = 16'($urandom);
    endtask

    task automatic wait_timeout(input bit sp);
        data_load = 1'b0;
        for (int i = 0; i < T - 1; i++) begin
            spur(sp);
            tick();
        end
        req_valid = 1'b0;
        tick();
        exp_status = 3'b110;
        exp_busy   = 1'b0;
    endtask

    task automatic do_req(input logic [1:0] req, input int uid, input logic [15:0] pin,
                          input logic [15:0] newpin, input int d1, input int d2,
                          input bit to1, input bit to2, input bit pre_high, input bit sp);
        req_valid = 1'b1;
        request   = req;
        user_id   = 2'(uid);
        if (pre_high) begin
            data_load = 1'b1;
            data_in   = 16'($urandom);
        end
        tick();
        req_valid = 1'b0;
        if (cyc < m_lock_free[uid]) begin
            exp_status = 3'b100; exp_busy = 1'b0;
            return;
        end
        if ((req == ENROLL) == m_valid[uid]) begin
            exp_status = 3'b111; exp_busy = 1'b0;
            return;
        end
        exp_status = 3'b001; exp_busy = 1'b1;
        if (to1) begin
            wait_timeout(sp);
            return;
        end
        load_pin(d1, pin, sp);
        tick();
        data_load = 1'b0;
        tick();
        exp_busy = 1'b0;
        if (req == ENROLL) begin
            m_pin[uid] = pin; m_valid[uid] = 1; exp_status = 3'b101;
        end else if (pin == m_pin[uid]) begin
            if (req == VERIFY) begin
                m_fail[uid] = 0; exp_status = 3'b010; exp_grant = 1'b1;
            end else if (req == CLEAR) begin
                m_valid[uid] = 0; m_fail[uid] = 0; exp_status = 3'b101;
            end else begin
                exp_busy = 1'b1;
                if (to2) begin
                    wait_timeout(sp);
                end else begin
                    load_pin(d2, newpin, sp);
                    data_load = 1'b0;
                    tick();
                    m_pin[uid] = newpin; exp_status = 3'b101; exp_busy = 1'b0;
                end
            end
        end else if (m_fail[uid] + 1 >= MAXT) begin
            m_fail[uid] = 0;
            m_lock_free[uid] = cyc + LC + 1;
            exp_status = 3'b100;
        end else begin
            m_fail[uid]++;
            exp_status = 3'b011;
        end
    endtask

    task automatic simple(input logic [1:0] req, input int uid, input logic [15:0] pin,
                          input logic [15:0] newpin);
        do_req(req, uid, pin, newpin, 2, 3, 0, 0, 0, 0);
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit reached", $time);
        $fatal(1);
    end

    initial begin
        model_reset();
        tick();
        check_lit("reset_status", status_frame, 3'b000);
        check_lit("reset_busy", {2'b00, busy}, 3'b000);
        tick();
        rst = 1'b0;
        tick();

        // 1: enroll and verify
        simple(ENROLL, 1, 16'h1476, 0);
        check_lit("t1_enroll", status_frame, 3'b101);
        simple(VERIFY, 1, 16'h1476, 0);
        check_lit("t1_grant_status", status_frame, 3'b010);
        check_lit("t1_grant_pulse", {2'b00, grant}, 3'b001);
        tick();
        check_lit("t1_grant_drop", {2'b00, grant}, 3'b000);

        // 2: lockout
        simple(VERIFY, 1, 16'h2456, 0);
        check_lit("t2_denied1", status_frame, 3'b011);
        simple(VERIFY, 1, 16'h2456, 0);
        check_lit("t2_denied2", status_frame, 3'b011);
        simple(VERIFY, 1, 16'h2456, 0);
        check_lit("t2_locked", status_frame, 3'b100);
        simple(VERIFY, 1, 16'h1476, 0);
        check_lit("t2_locked_right_pin", status_frame, 3'b100);

        // 3: other users unaffected
        simple(ENROLL, 2, 16'hBEEF, 0);
        check_lit("t3_enroll2", status_frame, 3'b101);
        simple(VERIFY, 2, 16'hBEEF, 0);
        check_lit("t3_grant2", status_frame, 3'b010);

        // lock boundary: last locked accept edge, then first free one
        while (cyc < m_lock_free[1] - 2) tick();
        simple(VERIFY, 1, 16'h1476, 0);
        check_lit("t2_lock_last_cycle", status_frame, 3'b100);
        simple(VERIFY, 1, 16'h1476, 0);
        check_lit("t2_unlocked_grant", status_frame, 3'b010);

        // 4: error cases
        simple(VERIFY, 3, 16'h1234, 0);
        check_lit("t4_unenrolled", status_frame, 3'b111);
        check_lit("t4_no_busy", {2'b00, busy}, 3'b000);
        simple(ENROLL, 1, 16'h1111, 0);
        check_lit("t4_reenroll", status_frame, 3'b111);

        // 5: change
        simple(CHANGE, 1, 16'h1476, 16'h2456);
        check_lit("t5_change_done", status_frame, 3'b101);
        simple(VERIFY, 1, 16'h1476, 0);
        check_lit("t5_old_denied", status_frame, 3'b011);
        simple(VERIFY, 1, 16'h2456, 0);
        check_lit("t5_new_grant", status_frame, 3'b010);

        // 6: timeout, then reset mid-wait
        do_req(VERIFY, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        check_lit("t6_timeout", status_frame, 3'b110);
        req_valid = 1'b1; request = VERIFY; user_id = 2'd1;
        tick();
        req_valid = 1'b0;
        exp_status = 3'b001; exp_busy = 1'b1;
        tick(); tick();
        #2;
        rst = 1'b1;
        exp_status = 3'b000; exp_busy = 1'b0;
        #1;
        check_lit("t6_rst_status", status_frame, 3'b000);
        check_lit("t6_rst_busy", {2'b00, busy}, 3'b000);
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        simple(VERIFY, 1, 16'h2456, 0);
        check_lit("t6_slot1_invalid", status_frame, 3'b111);
        simple(VERIFY, 2, 16'hBEEF, 0);
        check_lit("t6_slot2_invalid", status_frame, 3'b111);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int uid;
            logic [1:0] rq;
            logic [15:0] p;
            uid = int'($urandom % 4);
            rq  = (!m_valid[uid] && ($urandom % 4 != 0)) ? ENROLL : 2'($urandom);
            p   = (m_valid[uid] && ($urandom % 3 != 0)) ? m_pin[uid] : 16'($urandom);
            do_req(rq, uid, p, 16'($urandom), int'($urandom % (T - 2)), int'($urandom % (T - 2)),
                   ($urandom % 20 == 0), ($urandom % 10 == 0), ($urandom % 4 == 0),
                   ($urandom % 2 == 0));
            if ($urandom % 10 == 0) begin
                for (int g = 0; g < 55; g++) tick();
            end else begin
                for (int g = 0; g < int'($urandom % 3); g++) begin
                    data_load = 1'($urandom);
                    tick();
                end
            end
        end

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
